// File: rtl/tlc_pkg.sv
// Shared types and default timing for the demand-actuated phase scheduler.
// Phase encodings are visible on the phase output, so they are fixed here.
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_NS_G     = 3'd0,
    ST_NS_Y     = 3'd1,
    ST_AR_TO_EW = 3'd2,
    ST_EW_G     = 3'd3,
    ST_EW_Y     = 3'd4,
    ST_AR_TO_NS = 3'd5,
    ST_WALK     = 3'd6
  } state_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  localparam int DEF_MIN_GREEN = 5;
  localparam int DEF_MAX_GREEN = 15;
  localparam int DEF_YELLOW    = 3;
  localparam int DEF_ALL_RED   = 1;
  localparam int DEF_WALK      = 6;
  localparam int DEF_CW        = 5;

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// Sensor/request inputs and lamp outputs of the phase scheduler.
// The scheduler uses the slave modport; the environment drives the master side.
interface tlc_phase_scheduler_if;

  logic       tick;
  logic       ns_car;
  logic       ew_car;
  logic       ped_req;
  logic       emerg_ns;
  logic       emerg_ew;
  logic       ns_r;
  logic       ns_y;
  logic       ns_g;
  logic       ew_r;
  logic       ew_y;
  logic       ew_g;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (
    output tick, ns_car, ew_car, ped_req, emerg_ns, emerg_ew,
    input  ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, ped_pending, phase
  );

  modport slave (
    input  tick, ns_car, ew_car, ped_req, emerg_ns, emerg_ew,
    output ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, ped_pending, phase
  );

endinterface

// File: rtl/tlc_tick_counter.sv
// Saturating tick counter for phase timing: clear wins over tick, so a tick
// that coincides with a phase change is not counted in the new phase.
module tlc_tick_counter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          tick,
  input  logic [CW-1:0] cmp_val,
  output logic [CW-1:0] cnt,
  output logic          at_val
);

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_val = (cnt == cmp_val);

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Demand-actuated NS/EW phase scheduler with pedestrian walk and emergency
// preemption; lamps are Moore-decoded straight from the state register.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int YELLOW    = DEF_YELLOW,
  parameter int ALL_RED   = DEF_ALL_RED,
  parameter int WALK      = DEF_WALK,
  parameter int CW        = DEF_CW
) (
  input logic                  clk,
  input logic                  rst_n,
  tlc_phase_scheduler_if.slave bus
);

  localparam logic [CW-1:0] MIN_M1  = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_M1  = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YEL_M1  = CW'(YELLOW - 1);
  localparam logic [CW-1:0] AR_M1   = CW'(ALL_RED - 1);
  localparam logic [CW-1:0] WALK_M1 = CW'(WALK - 1);

  state_e        state, state_nx;
  dir_e          next_dir, next_dir_nx;
  logic          ped_latch;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cmp_val;
  logic          at_val;
  logic          timed_done;
  logic          ns_demand_exit, ew_demand_exit;
  logic          ns_green_done, ew_green_done;

  tlc_tick_counter #(.CW(CW)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_nx != state),
    .tick    (bus.tick),
    .cmp_val (cmp_val),
    .cnt     (cnt),
    .at_val  (at_val)
  );

  // Demand-driven exit: minimum served, someone waiting, and own traffic gone or max reached.
  assign ns_demand_exit = (cnt >= MIN_M1) && (bus.ew_car || ped_latch) &&
                          (!bus.ns_car || (cnt >= MAX_M1));
  assign ew_demand_exit = (cnt >= MIN_M1) && (bus.ns_car || ped_latch) &&
                          (!bus.ew_car || (cnt >= MAX_M1));

  // NS preemption outranks EW preemption: NS green holds, EW green yields.
  assign ns_green_done = !bus.emerg_ns && (bus.emerg_ew || ns_demand_exit);
  assign ew_green_done = bus.emerg_ns || (!bus.emerg_ew && ew_demand_exit);

  assign timed_done = bus.tick && at_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_NS_G;
      next_dir <= DIR_EW;
    end else begin
      state    <= state_nx;
      next_dir <= next_dir_nx;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx    = state;
    next_dir_nx = next_dir;
    cmp_val     = '0;
    case (state)
      ST_NS_G: if (bus.tick && ns_green_done) state_nx = ST_NS_Y;
      ST_NS_Y: begin
        cmp_val = YEL_M1;
        if (timed_done) state_nx = ST_AR_TO_EW;
      end
      ST_AR_TO_EW: begin
        cmp_val = AR_M1;
        if (timed_done) begin
          next_dir_nx = DIR_EW;
          state_nx    = ped_latch ? ST_WALK : ST_EW_G;
        end
      end
      ST_EW_G: if (bus.tick && ew_green_done) state_nx = ST_EW_Y;
      ST_EW_Y: begin
        cmp_val = YEL_M1;
        if (timed_done) state_nx = ST_AR_TO_NS;
      end
      ST_AR_TO_NS: begin
        cmp_val = AR_M1;
        if (timed_done) begin
          next_dir_nx = DIR_NS;
          state_nx    = ped_latch ? ST_WALK : ST_NS_G;
        end
      end
      ST_WALK: begin
        cmp_val = WALK_M1;
        if (timed_done) state_nx = (next_dir == DIR_EW) ? ST_EW_G : ST_NS_G;
      end
      default: state_nx = ST_AR_TO_NS;
    endcase
  end

  // Request is latched outside WALK and retired when WALK ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_latch <= 1'b0;
    end else if (state == ST_WALK) begin
      if (state_nx != ST_WALK) ped_latch <= 1'b0;
    end else if (bus.ped_req) begin
      ped_latch <= 1'b1;
    end
  end

  always_comb begin
    bus.ns_r = 1'b1;
    bus.ns_y = 1'b0;
    bus.ns_g = 1'b0;
    bus.ew_r = 1'b1;
    bus.ew_y = 1'b0;
    bus.ew_g = 1'b0;
    bus.walk = 1'b0;
    case (state)
      ST_NS_G: begin bus.ns_r = 1'b0; bus.ns_g = 1'b1; end
      ST_NS_Y: begin bus.ns_r = 1'b0; bus.ns_y = 1'b1; end
      ST_EW_G: begin bus.ew_r = 1'b0; bus.ew_g = 1'b1; end
      ST_EW_Y: begin bus.ew_r = 1'b0; bus.ew_y = 1'b1; end
      ST_WALK: bus.walk = 1'b1;
      default: ;
    endcase
  end

  assign bus.phase       = state;
  assign bus.ped_pending = ped_latch;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Scoreboard bench: a phase-level reference model predicts every post-edge
// observation, and an independent monitor compares it against the DUT.
module tb_tlc_phase_scheduler;

  localparam int MIN_G = 5;
  localparam int MAX_G = 15;
  localparam int YEL   = 3;
  localparam int AR    = 1;
  localparam int WLK   = 6;

  localparam int P_NS_G  = 0;
  localparam int P_NS_Y  = 1;
  localparam int P_AR_EW = 2;
  localparam int P_EW_G  = 3;
  localparam int P_EW_Y  = 4;
  localparam int P_AR_NS = 5;
  localparam int P_WALK  = 6;

  typedef struct packed {
    logic [2:0] phase;
    logic [5:0] lamps;  // {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g}
    logic       walk;
    logic       pend;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  tlc_phase_scheduler_if bus ();

  tlc_phase_scheduler #(
    .MIN_GREEN (MIN_G),
    .MAX_GREEN (MAX_G),
    .YELLOW    (YEL),
    .ALL_RED   (AR),
    .WALK      (WLK),
    .CW        (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: phase number, ticks spent in it, where WALK leads, request latch.
  int m_phase;
  int m_ticks;
  bit m_walk_to_ew;
  bit m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [5:0] lamps_for(input int p);
    case (p)
      P_NS_G:  return 6'b001_100;
      P_NS_Y:  return 6'b010_100;
      P_EW_G:  return 6'b100_001;
      P_EW_Y:  return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  function automatic bit green_ends(input bit ew_has_green);
    bit own_car, opp_car, own_em, opp_em;
    own_car = ew_has_green ? bus.ew_car : bus.ns_car;
    opp_car = ew_has_green ? bus.ns_car : bus.ew_car;
    own_em  = ew_has_green ? bus.emerg_ew : bus.emerg_ns;
    opp_em  = ew_has_green ? bus.emerg_ns : bus.emerg_ew;
    if (own_em && opp_em) return ew_has_green;
    if (own_em) return 1'b0;
    if (opp_em) return 1'b1;
    return (m_ticks >= MIN_G - 1) && (opp_car || m_pend) &&
           (!own_car || (m_ticks >= MAX_G - 1));
  endfunction

  function automatic bit timed_over(input int dur);
    return bus.tick && (m_ticks == dur - 1);
  endfunction

  task automatic model_reset();
    m_phase      = P_NS_G;
    m_ticks      = 0;
    m_walk_to_ew = 1'b1;
    m_pend       = 1'b0;
  endtask

  task automatic model_step();
    int   nxt;
    obs_t e;
    nxt = m_phase;
    case (m_phase)
      P_NS_G:  if (bus.tick && green_ends(1'b0)) nxt = P_NS_Y;
      P_NS_Y:  if (timed_over(YEL)) nxt = P_AR_EW;
      P_AR_EW: if (timed_over(AR)) begin
        m_walk_to_ew = 1'b1;
        nxt = m_pend ? P_WALK : P_EW_G;
      end
      P_EW_G:  if (bus.tick && green_ends(1'b1)) nxt = P_EW_Y;
      P_EW_Y:  if (timed_over(YEL)) nxt = P_AR_NS;
      P_AR_NS: if (timed_over(AR)) begin
        m_walk_to_ew = 1'b0;
        nxt = m_pend ? P_WALK : P_NS_G;
      end
      default: if (timed_over(WLK)) nxt = m_walk_to_ew ? P_EW_G : P_NS_G;
    endcase
    if (m_phase == P_WALK) begin
      if (nxt != P_WALK) m_pend = 1'b0;
    end else if (bus.ped_req) begin
      m_pend = 1'b1;
    end
    if (nxt != m_phase) m_ticks = 0;
    else if (bus.tick) m_ticks++;
    m_phase = nxt;
    e.phase = 3'(m_phase);
    e.lamps = lamps_for(m_phase);
    e.walk  = (m_phase == P_WALK);
    e.pend  = m_pend;
    exp_q.push_back(e);
  endtask

  // Monitor: one observation per clock, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (exp_q.size() > 0)) begin
        obs_t e;
        e = exp_q.pop_front();
        check("phase", 32'(bus.phase), 32'(e.phase));
        check("lamps", 32'({bus.ns_r, bus.ns_y, bus.ns_g, bus.ew_r, bus.ew_y, bus.ew_g}),
              32'(e.lamps));
        check("walk_pend", 32'({bus.walk, bus.ped_pending}), 32'({e.walk, e.pend}));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.tick = 1'b1;
      cycle();
      bus.tick = 1'b0;
      cycle();
    end
  endtask

  task automatic clear_inputs();
    bus.tick     = 1'b0;
    bus.ns_car   = 1'b0;
    bus.ew_car   = 1'b0;
    bus.ped_req  = 1'b0;
    bus.emerg_ns = 1'b0;
    bus.emerg_ew = 1'b0;
  endtask

  // Called at a falling edge; asserts reset mid-cycle and checks the immediate response.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_phase", 32'(bus.phase), 32'(P_NS_G));
    check("rst_lamps", 32'({bus.ns_r, bus.ns_y, bus.ns_g, bus.ew_r, bus.ew_y, bus.ew_g}),
          32'(6'b001_100));
    check("rst_walk", 32'(bus.walk), 32'd0);
    check("rst_pend", 32'(bus.ped_pending), 32'd0);
    exp_q.delete();
    model_reset();
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_phase(input string name, input int p);
    check(name, 32'(bus.phase), 32'(p));
  endtask

  initial begin
    clear_inputs();
    model_reset();
    @(negedge clk);

    // Own traffic only: NS green rests.
    do_reset();
    bus.ns_car = 1'b1;
    ticks(100);
    expect_phase("ns_rest_phase", P_NS_G);
    check("ns_rest_g", 32'(bus.ns_g), 32'd1);

    // Opposing demand only: minimum green, then yellow and all-red.
    do_reset();
    bus.ew_car = 1'b1;
    ticks(4);
    expect_phase("min_green_hold", P_NS_G);
    ticks(1);
    expect_phase("min_green_exit", P_NS_Y);
    ticks(3);
    expect_phase("yellow_len", P_AR_EW);
    ticks(1);
    expect_phase("all_red_len", P_EW_G);

    // Both approaches busy: max green and 38-tick cycle.
    do_reset();
    bus.ns_car = 1'b1;
    bus.ew_car = 1'b1;
    ticks(14);
    expect_phase("max_green_hold", P_NS_G);
    ticks(1);
    expect_phase("max_green_exit", P_NS_Y);
    ticks(38);
    expect_phase("cycle_38", P_NS_Y);

    // Pedestrian request served between AR_TO_EW and EW_G.
    do_reset();
    bus.ew_car = 1'b1;
    ticks(2);
    bus.ped_req = 1'b1;
    cycle();
    bus.ped_req = 1'b0;
    check("ped_latched", 32'(bus.ped_pending), 32'd1);
    ticks(3);
    expect_phase("ped_ns_exit", P_NS_Y);
    ticks(4);
    expect_phase("walk_entered", P_WALK);
    check("walk_lamp", 32'(bus.walk), 32'd1);
    bus.ped_req = 1'b1;
    cycle();
    bus.ped_req = 1'b0;
    ticks(6);
    expect_phase("walk_to_ew", P_EW_G);
    check("ped_cleared", 32'(bus.ped_pending), 32'd0);

    // Emergency preemption and NS priority.
    do_reset();
    ticks(1);
    bus.emerg_ew = 1'b1;
    ticks(1);
    expect_phase("emerg_waives_min", P_NS_Y);
    ticks(4);
    expect_phase("emerg_to_ew", P_EW_G);
    bus.ns_car = 1'b1;
    bus.ew_car = 1'b1;
    ticks(20);
    expect_phase("emerg_hold_ew", P_EW_G);
    bus.emerg_ns = 1'b1;
    ticks(1);
    expect_phase("ns_priority_exit", P_EW_Y);
    ticks(4);
    ticks(10);
    expect_phase("ns_priority_hold", P_NS_G);

    // Reset in the middle of EW yellow with a pending walk.
    do_reset();
    bus.ew_car = 1'b1;
    ticks(9);
    expect_phase("pre_rst_ew", P_EW_G);
    bus.ew_car  = 1'b0;
    bus.ped_req = 1'b1;
    cycle();
    bus.ped_req = 1'b0;
    ticks(6);
    expect_phase("pre_rst_ewy", P_EW_Y);
    check("pre_rst_pend", 32'(bus.ped_pending), 32'd1);
    do_reset();

    // Randomised traffic, requests, emergencies and occasional resets.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.ns_car = ~bus.ns_car;
      if ($urandom_range(0, 19) == 0) bus.ew_car = ~bus.ew_car;
      if ($urandom_range(0, 299) == 0) bus.emerg_ns = ~bus.emerg_ns;
      if ($urandom_range(0, 299) == 0) bus.emerg_ew = ~bus.emerg_ew;
      bus.ped_req = ($urandom_range(0, 39) == 0);
      bus.tick    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1499) == 0) do_reset();
      else cycle();
    end

    #1;
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
